fe_mul_arb: RTL and testbench
=============================

FE_MUL_ARB -- requirements
Module: fe_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter MUL_LAT, default 8: fixed latency in cycles of the external pipelined fe_mul_mont multiplier, 1..32.
REQ-003 SHALL have parameter MAX_OUT, default 4: per-requester in-flight cap, 1..15.
REQ-004 i_clk  in  1  sole clock; all logic rising-edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req_val  in  NUM_REQ  per-requester operand valid.
REQ-007 i_req_dat  in  NUM_REQ x fe_mul_req_t  operands {a,b}, 256 b each.
REQ-008 o_req_rdy  out  NUM_REQ  one-hot or zero grant; transfer when val&rdy.
REQ-009 o_mul_val / o_mul_a / o_mul_b  out  1/256/256  registered issue to multiplier.
REQ-010 i_mul_val / i_mul_res  in  1/256  multiplier result, MUL_LAT cycles after issue.
REQ-011 o_res_val  out  NUM_REQ  one-hot result strobe to owning requester; no backpressure.
REQ-012 o_res_dat  out  256  result, shared by all requesters.
REQ-013 i_flush / o_flush_done  in/out  1/1  drain request / one-cycle drained pulse.
REQ-014 o_err  out  1  sticky tag-pipeline mismatch flag.
REQ-015 o_issue_cnt  out  32  total issued operations (see Configuration).

Function
REQ-016 SHALL grant at most one requester per cycle, round-robin starting after the last granted index.
REQ-017 SHALL exclude a requester from grant while its in-flight count equals MAX_OUT.
REQ-018 o_req_rdy SHALL be combinational from i_req_val, RR pointer, counts and state; never asserted without i_req_val.
REQ-019 On transfer, SHALL register operands to o_mul_a/b with o_mul_val=1 the next cycle and push the grant index into a MUL_LAT+1 deep tag shift register.
REQ-020 On tag-pipe exit, SHALL register i_mul_res to o_res_dat and assert o_res_val[tag] one cycle later; request-to-result latency is exactly MUL_LAT+2.
REQ-021 Same-requester increment (grant) and decrement (result) in one cycle SHALL leave its count unchanged.
REQ-022 i_mul_val without a valid tag exiting, or a valid tag without i_mul_val, SHALL set o_err; the result is dropped and the tag's count is still decremented.
REQ-023 FSM RUN/DRAIN/DONE: RUN grants; i_flush in RUN -> DRAIN (no grants); DRAIN with all counts zero and tag pipe empty -> DONE; DONE asserts o_flush_done one cycle -> RUN.
REQ-024 i_flush held in DONE SHALL return to DRAIN, not RUN.
REQ-025 RR pointer SHALL wrap NUM_REQ-1 -> 0 and hold when no grant occurs.

Reset
REQ-026 Reset SHALL clear o_req_rdy, o_mul_val, o_res_val, o_flush_done, o_err, o_issue_cnt, all counts and tags; o_mul_a/b and o_res_dat to 0; FSM to RUN; RR pointer to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight tags; multiplier results returning after deassertion SHALL set o_err.

Configuration
REQ-028 With FE_MUL_ARB_STATS_EN defined, o_issue_cnt SHALL increment per issue, saturating at 2^32-1; without it, o_issue_cnt SHALL be tied to 0 and no counter SHALL be synthesised.

Structure
REQ-029 fe_mul_req_t (packed {fe_t b; fe_t a}) SHALL live in bn128_pkg; fe_t comes from there.
REQ-030 Round-robin selection SHALL be the sub-module rr_arb (NUM_REQ request/mask in, one-hot grant out, pointer internal).

Verification
REQ-031 Reset, single request from req 2 with a=CONST_3, b=CONST_4 -> o_res_val[2] exactly 10 cycles after transfer (MUL_LAT=8), o_res_dat = multiplier output.
REQ-032 All four requesting continuously -> grants 0,1,2,3,0,... one per cycle; o_issue_cnt=8 after 8 transfers (macro on), 0 (macro off).
REQ-033 Req 0 only, MAX_OUT=4 -> four consecutive grants, then o_req_rdy[0]=0 until the first result returns, then granted the same cycle.
REQ-034 i_flush with 3 in flight -> no grants, o_flush_done one cycle after the last o_res_val; FSM back in RUN.
REQ-035 Inject i_mul_val with empty tag pipe -> o_err=1, no o_res_val, o_err held until i_rst_n low.
REQ-036 Assert i_rst_n low with 5 in flight -> all outputs at reset values immediately; returning results set o_err.

Source files
------------

// File: rtl/bn128_pkg.sv
// bn128_pkg -- shared BN128 field types.
//   fe_t          : 256-bit field element
//   fe_mul_req_t  : multiplier operand pair, packed {b, a}
//   CONST_3/4     : small field constants used as reference operands
package bn128_pkg;

    typedef logic [255:0] fe_t;

    typedef struct packed {
        fe_t b;
        fe_t a;
    } fe_mul_req_t;

    localparam fe_t CONST_3 = fe_t'(3);
    localparam fe_t CONST_4 = fe_t'(4);

endpackage

// File: rtl/fe_mul_arb_pkg.sv
// fe_mul_arb_pkg -- arbiter-local types.
//   arb_state_e : RUN (granting) / DRAIN (flush, no grants) / DONE (drained pulse)
//   CNT_W       : width of the per-requester in-flight counters (MAX_OUT <= 15)
package fe_mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } arb_state_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/fe_mul_arb_if.sv
// fe_mul_arb_if -- bundle between requesters, the arbiter and the external
// pipelined fe_mul_mont multiplier.
//   slave  : arbiter side (drives o_*, samples i_*)
//   master : environment side (requesters + multiplier)
//   i_req_val/i_req_dat/o_req_rdy : per-requester operand handshake
//   o_mul_val/o_mul_a/o_mul_b     : registered issue to the multiplier
//   i_mul_val/i_mul_res           : multiplier result, MUL_LAT cycles after issue
//   o_res_val/o_res_dat           : one-hot result strobe + shared result bus
//   i_flush/o_flush_done          : drain request / drained pulse
//   o_err                         : sticky tag-pipeline mismatch
//   o_issue_cnt                   : issued-operation counter (0 unless stats built)
interface fe_mul_arb_if #(
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]                    i_req_val;
    bn128_pkg::fe_mul_req_t [NUM_REQ-1:0] i_req_dat;
    logic [NUM_REQ-1:0]                    o_req_rdy;
    logic                                  o_mul_val;
    bn128_pkg::fe_t                        o_mul_a;
    bn128_pkg::fe_t                        o_mul_b;
    logic                                  i_mul_val;
    bn128_pkg::fe_t                        i_mul_res;
    logic [NUM_REQ-1:0]                    o_res_val;
    bn128_pkg::fe_t                        o_res_dat;
    logic                                  i_flush;
    logic                                  o_flush_done;
    logic                                  o_err;
    logic [31:0]                           o_issue_cnt;

    modport slave (
        input  i_req_val, i_req_dat, i_mul_val, i_mul_res, i_flush,
        output o_req_rdy, o_mul_val, o_mul_a, o_mul_b, o_res_val, o_res_dat,
               o_flush_done, o_err, o_issue_cnt
    );

    modport master (
        output i_req_val, i_req_dat, i_mul_val, i_mul_res, i_flush,
        input  o_req_rdy, o_mul_val, o_mul_a, o_mul_b, o_res_val, o_res_dat,
               o_flush_done, o_err, o_issue_cnt
    );

endinterface

// File: rtl/fe_mul_arb_rr_arb.sv
// rr_arb -- round-robin arbiter, combinational one-hot grant.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-requester request
//   i_mask         : per-requester eligibility (0 removes it from the search)
//   o_gnt          : one-hot or zero grant
// The priority pointer sits one past the last granted index, wraps to 0 and
// holds when nothing is granted.
module rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    output logic [NUM_REQ-1:0] o_gnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      idx;
    logic [PW-1:0]      gnt_idx;
    logic               found;
    logic [NUM_REQ-1:0] elig;

    assign elig = i_req & i_mask;

    // NOTE: every variable gets a default before the loop so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        o_gnt   = '0;
        found   = 1'b0;
        idx     = '0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && elig[idx]) begin
                o_gnt[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/fe_mul_arb.sv
// fe_mul_arb -- arbitrates NUM_REQ requesters onto one pipelined field
// multiplier and routes each result back to its owner via a tag shift register.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : fe_mul_arb_if.slave (handshake, multiplier, results, flush, status)
// Parameters: NUM_REQ (2..8), MUL_LAT (1..32), MAX_OUT (1..15).
// Build option: define FE_MUL_ARB_STATS_EN to implement the saturating
// o_issue_cnt counter; otherwise o_issue_cnt is tied to 0.
module fe_mul_arb
    import bn128_pkg::*;
    import fe_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 8,
    parameter int MAX_OUT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fe_mul_arb_if.slave bus
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt [NUM_REQ];
    logic [NUM_REQ-1:0] not_full;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               xfer;
    logic               run_en;
    logic               all_zero;
    logic [MUL_LAT:0]   tag_vld;
    logic [PW-1:0]      tag_idx [MUL_LAT+1];
    logic               exit_vld;
    logic [PW-1:0]      exit_tag;

    always_comb begin
        not_full = '0;
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            not_full[i] = (cnt[i] != CNT_W'(MAX_OUT));
            if (cnt[i] != '0) all_zero = 1'b0;
        end
    end

    // Grants only in RUN; gated by reset too so o_req_rdy is low while reset is held.
    assign run_en = (state == ST_RUN) && i_rst_n;

    rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (bus.i_req_val),
        .i_mask  (not_full & {NUM_REQ{run_en}}),
        .o_gnt   (gnt)
    );

    // Grant is already qualified by i_req_val, so a grant is a transfer.
    assign bus.o_req_rdy = gnt;
    assign xfer          = |gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    // Operand issue register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_mul_val <= 1'b0;
            bus.o_mul_a   <= '0;
            bus.o_mul_b   <= '0;
        end else begin
            bus.o_mul_val <= xfer;
            if (xfer) begin
                bus.o_mul_a <= bus.i_req_dat[gnt_idx].a;
                bus.o_mul_b <= bus.i_req_dat[gnt_idx].b;
            end
        end
    end

    // Tag pipe: MUL_LAT+1 stages so a tag exits in the same cycle as its
    // multiplier result (issue register adds one cycle ahead of the multiplier).
    assign exit_vld = tag_vld[MUL_LAT];
    assign exit_tag = tag_idx[MUL_LAT];

    // NOTE: the tag index stages are reset along with their valid bits; the
    // array is only MUL_LAT+1 short entries, and a clean reset keeps X out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s <= MUL_LAT; s++) tag_idx[s] <= '0;
        end else begin
            tag_vld    <= {tag_vld[MUL_LAT-1:0], xfer};
            tag_idx[0] <= gnt_idx;
            for (int s = 1; s <= MUL_LAT; s++) tag_idx[s] <= tag_idx[s-1];
        end
    end

    // In-flight counters: simultaneous grant and return cancel out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({gnt[i], exit_vld && (exit_tag == PW'(i))})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    // Result routing; a tag/result disagreement drops the result and sticks o_err.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_res_val <= '0;
            bus.o_res_dat <= '0;
            bus.o_err     <= 1'b0;
        end else begin
            bus.o_res_val <= '0;
            if (exit_vld && bus.i_mul_val) begin
                bus.o_res_val[exit_tag] <= 1'b1;
                bus.o_res_dat           <= bus.i_mul_res;
            end
            if (exit_vld != bus.i_mul_val) bus.o_err <= 1'b1;
        end
    end

    // Flush FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (bus.i_flush) state_nxt = ST_DRAIN;
            ST_DRAIN: if (all_zero && (tag_vld == '0)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = bus.i_flush ? ST_DRAIN : ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    assign bus.o_flush_done = (state == ST_DONE);

`ifdef FE_MUL_ARB_STATS_EN
    logic [31:0] issue_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                      issue_cnt <= '0;
        else if (xfer && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
    end

    assign bus.o_issue_cnt = issue_cnt;
`else
    assign bus.o_issue_cnt = '0;
`endif

endmodule

// File: tb/tb_fe_mul_arb.sv
// tb_fe_mul_arb -- directed bench for fe_mul_arb (NUM_REQ=4, MUL_LAT=8,
// MAX_OUT=4) with a behavioural pipelined multiplier (result = a*b mod 2^256).
module tb_fe_mul_arb;
    import bn128_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 8;
    localparam int MAX_OUT = 4;
`ifdef FE_MUL_ARB_STATS_EN
    localparam logic [31:0] EXP_ISSUE8 = 32'd8;
`else
    localparam logic [31:0] EXP_ISSUE8 = 32'd0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic inj   = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    fe_mul_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

    fe_mul_arb #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: not reset by the arbiter's reset.
    logic [MUL_LAT-1:0] mv = '0;
    fe_t                mr [MUL_LAT];
    always @(posedge clk) begin
        mv    <= {mv[MUL_LAT-2:0], bus.o_mul_val};
        mr[0] <= bus.o_mul_a * bus.o_mul_b;
        for (int k = 1; k < MUL_LAT; k++) mr[k] <= mr[k-1];
    end
    assign bus.i_mul_val = mv[MUL_LAT-1] | inj;
    assign bus.i_mul_res = mr[MUL_LAT-1];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rdy"},   bus.o_req_rdy, 0);
        check({pfx, "_mval"},  bus.o_mul_val, 0);
        check({pfx, "_ma"},    bus.o_mul_a, 0);
        check({pfx, "_mb"},    bus.o_mul_b, 0);
        check({pfx, "_rval"},  bus.o_res_val, 0);
        check({pfx, "_rdat"},  bus.o_res_dat, 0);
        check({pfx, "_done"},  bus.o_flush_done, 0);
        check({pfx, "_err"},   bus.o_err, 0);
        check({pfx, "_icnt"},  bus.o_issue_cnt, 0);
    endtask

    // Reset held long enough for the multiplier model to empty.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req_val = '0;
        bus.i_flush = 1'b0;
        inj = 1'b0;
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int lat, nres, bad, ndone, last_res, done_cyc;

        bus.i_req_val = '1;   // rdy must stay low while reset is held
        bus.i_flush   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.i_req_dat[i] = '0;

        // ---- reset state
        @(negedge clk); #1;
        check_reset_outputs("rst");
        bus.i_req_val = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- single request from req 2: latency MUL_LAT+2 = 10
        @(negedge clk);
        bus.i_req_dat[2] = '{b: CONST_4, a: CONST_3};
        bus.i_req_val = 4'b0100;
        #1;
        check("single_rdy", bus.o_req_rdy, 4'b0100);
        @(negedge clk);
        bus.i_req_val = '0;
        #1;
        check("issue_val", bus.o_mul_val, 1);
        check("issue_a", bus.o_mul_a, 256'd3);
        check("issue_b", bus.o_mul_b, 256'd4);
        lat = 1;
        while (bus.o_res_val == '0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("single_lat", lat, 10);
        check("single_rval", bus.o_res_val, 4'b0100);
        check("single_rdat", bus.o_res_dat, 256'd12);

        // ---- all four continuously: 0,1,2,3,0,1,2,3
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) bus.i_req_dat[i] = '{b: fe_t'(i + 5), a: fe_t'(i + 1)};
        bus.i_req_val = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rr_gnt%0d", i), bus.o_req_rdy, 4'b0001 << (i % 4));
            @(negedge clk);
        end
        bus.i_req_val = '0;
        #1;
        check("rr_issue_cnt", bus.o_issue_cnt, EXP_ISSUE8);
        repeat (15) @(negedge clk);
        check("rr_no_err", bus.o_err, 0);

        // ---- in-flight cap on req 0
        do_reset();
        @(negedge clk);
        bus.i_req_val = 4'b0001;
        #1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("cap_rdy%0d", k), bus.o_req_rdy, (k < 4) ? 4'b0001 : 4'b0000);
            @(negedge clk);
        end
        check("cap_res_back", bus.o_res_val, 4'b0001);
        check("cap_regrant", bus.o_req_rdy, 4'b0001);
        bus.i_req_val = '0;
        repeat (20) @(negedge clk);

        // ---- flush with 3 in flight
        do_reset();
        @(negedge clk);
        bus.i_req_val = 4'b0111;
        repeat (3) @(negedge clk);
        bus.i_req_val = '0;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        bus.i_req_val = 4'b1000;
        #1;
        bad = 0; ndone = 0; last_res = -100; done_cyc = -1;
        for (int c = 0; c < 30; c++) begin
            if (bus.o_res_val != '0) last_res = cyc;
            if (bus.o_flush_done) begin
                done_cyc = cyc;
                ndone++;
            end
            if (done_cyc < 0 && bus.o_req_rdy != '0) bad++;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("flush_back_run", bus.o_req_rdy, 4'b1000);
                break;
            end
            @(negedge clk);
        end
        bus.i_req_val = '0;
        check("flush_gap", done_cyc - last_res, 1);
        check("flush_no_gnt", bad, 0);
        check("flush_pulses", ndone, 1);

        // ---- result with empty tag pipe
        do_reset();
        @(negedge clk); #1;
        check("inj_pre_err", bus.o_err, 0);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        check("inj_err", bus.o_err, 1);
        nres = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.o_res_val != '0) nres++;
            @(negedge clk);
        end
        check("inj_no_res", nres, 0);
        check("inj_err_held", bus.o_err, 1);
        rst_n = 1'b0;
        #1;
        check("inj_err_clr", bus.o_err, 0);

        // ---- reset with 5 in flight
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_req_val = 4'b1111;
        repeat (5) @(negedge clk);
        check("mid_pre_mval", bus.o_mul_val, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        bus.i_req_val = '0;
        @(negedge clk);
        rst_n = 1'b1;
        nres = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.o_res_val != '0) nres++;
        end
        check("mid_no_res", nres, 0);
        check("mid_err", bus.o_err, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
